// File: rtl/reg_scoreboard.sv
// Register/CC issue scoreboard: saturating in-flight write counters per GPR and CC.
// Optional SCOREBOARD_PERF_EN adds a saturating dependency-stall counter (stall_cnt).
module reg_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 3,
    parameter int CNT_W    = 2,
    parameter int PERF_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                issue_valid,
    input  logic                sr1_needed,
    input  logic                sr2_needed,
    input  logic [REG_W-1:0]    sr1,
    input  logic [REG_W-1:0]    sr2,
    input  logic                de_br_op,
    input  logic                issue_ld_reg,
    input  logic [REG_W-1:0]    issue_dr,
    input  logic                issue_ld_cc,
    input  logic                retire_valid,
    input  logic                retire_ld_reg,
    input  logic [REG_W-1:0]    retire_dr,
    input  logic                retire_ld_cc,
    output logic                issue_ready,
    output logic                dep_stall,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                cc_pending,
    output logic                sb_err
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [PERF_W-1:0]   stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [CNT_W-1:0]    cc_cnt;
    logic [NUM_REGS-1:0] inc_r;
    logic [NUM_REGS-1:0] dec_r;
    logic                cc_inc;
    logic                cc_dec;
    logic                hazard;
    logic                fire;
    logic                err_evt;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
        cc_pending = (cc_cnt != '0);
        hazard = (sr1_needed && cnt[sr1] != '0)
              || (sr2_needed && cnt[sr2] != '0)
              || (de_br_op && cc_pending)
              || (issue_ld_reg && cnt[issue_dr] == MAX)
              || (issue_ld_cc && cc_cnt == MAX);
        issue_ready = !hazard && !flush;
        dep_stall   = issue_valid && !issue_ready;
        fire        = issue_valid && issue_ready;
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_r[r] = fire && issue_ld_reg && (issue_dr == REG_W'(r));
            dec_r[r] = retire_valid && retire_ld_reg && (retire_dr == REG_W'(r));
        end
        cc_inc = fire && issue_ld_cc;
        cc_dec = retire_valid && retire_ld_cc;
        // A flush squashes the retire as well, so it cannot raise an error.
        err_evt = !flush
               && ((|(dec_r & ~inc_r & ~busy_vec))
                   || (cc_dec && !cc_inc && !cc_pending));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            cc_cnt <= '0;
            sb_err <= 1'b0;
        end else begin
            if (err_evt) begin
                sb_err <= 1'b1;
            end
            for (int r = 0; r < NUM_REGS; r++) begin
                if (flush) begin
                    cnt[r] <= '0;
                end else if (inc_r[r] && !dec_r[r]) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (dec_r[r] && !inc_r[r] && busy_vec[r]) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
            if (flush) begin
                cc_cnt <= '0;
            end else if (cc_inc && !cc_dec) begin
                cc_cnt <= cc_cnt + CNT_W'(1);
            end else if (cc_dec && !cc_inc && cc_pending) begin
                cc_cnt <= cc_cnt - CNT_W'(1);
            end
        end
    end

`ifdef SCOREBOARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (dep_stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end
`endif

endmodule
